// File: rtl/uncache_wbuf_pkg.sv
// Shared types and constants for the uncached store write buffer.
package uncache_wbuf_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  // Drain FSM encodings
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } wb_state_e;

  // AXI size and burst encodings
  localparam logic [2:0] SIZE_B     = 3'd0;
  localparam logic [2:0] SIZE_H     = 3'd1;
  localparam logic [2:0] SIZE_W     = 3'd2;
  localparam logic [1:0] BURST_INCR = 2'b01;

  // One queued store
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] wen;
    logic [DATA_W-1:0] wdata;
  } wbuf_entry_t;

  localparam int unsigned ENTRY_W = $bits(wbuf_entry_t);

  // Byte offset of the lowest enabled lane
  function automatic logic [1:0] wen_offset(input logic [STRB_W-1:0] wen);
    logic [1:0] off;
    off = 2'd0;
    if (wen[0])      off = 2'd0;
    else if (wen[1]) off = 2'd1;
    else if (wen[2]) off = 2'd2;
    else if (wen[3]) off = 2'd3;
    return off;
  endfunction

  // Transfer size implied by the byte-enable pattern
  function automatic logic [2:0] wen_size(input logic [STRB_W-1:0] wen);
    logic [2:0] sz;
    case (wen)
      4'b1111:          sz = SIZE_W;
      4'b0011, 4'b1100: sz = SIZE_H;
      default:          sz = SIZE_B;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// Small synchronous FIFO holding queued stores; push ignored when full, pop ignored when empty.
module wbuf_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 68,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy
  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    mem_d    = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = din;
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uncache_wbuf.sv
// Uncached store write buffer: queues stores and drains them one at a time as single-beat AXI writes.
module uncache_wbuf
  import uncache_wbuf_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter logic [3:0]  AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic [3:0]  req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        empty,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  input  logic [1:0]  bresp,
  output logic        bready
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  wb_state_e         state_q, state_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              wlast_q, wlast_d;
  logic              bready_q, bready_d;
  logic [31:0]       awaddr_q, awaddr_d;
  logic [2:0]        awsize_q, awsize_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              empty_q, empty_d;

  wbuf_entry_t       push_entry, head;
  logic [CNT_W-1:0]  count, cnt_next;
  logic              full, fifo_empty, pop_c;
  logic              unused_c;

  assign push_entry = {req_addr, req_wen, req_wdata};
  assign stall      = req_en & full;
  assign unused_c   = ^{bresp, head.addr[1:0]};

  wbuf_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_en),
    .pop   (pop_c),
    .din   (push_entry),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (fifo_empty)
  );

  // Drain FSM: next state and next values of the registered AXI outputs
  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    wlast_d   = wlast_q;
    bready_d  = bready_q;
    awaddr_d  = awaddr_q;
    awsize_d  = awsize_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    pop_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count != '0) begin
          state_d   = ST_AW;
          awvalid_d = 1'b1;
          awaddr_d  = {head.addr[31:2], wen_offset(head.wen)};
          awsize_d  = wen_size(head.wen);
          wdata_d   = head.wdata;
          wstrb_d   = head.wen;
        end
      end
      ST_AW: begin
        if (awready) begin
          state_d   = ST_W;
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          wlast_d   = 1'b1;
        end
      end
      ST_W: begin
        if (wready) begin
          state_d  = ST_B;
          wvalid_d = 1'b0;
          wlast_d  = 1'b0;
          bready_d = 1'b1;
        end
      end
      ST_B: begin
        if (bvalid) begin
          state_d  = ST_IDLE;
          bready_d = 1'b0;
          pop_c    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cnt_next = count + CNT_W'(req_en & ~full) - CNT_W'(pop_c & ~fifo_empty);
    empty_d  = (cnt_next == '0) & (state_d == ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      awaddr_q  <= '0;
      awsize_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      empty_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wlast_q   <= wlast_d;
      bready_q  <= bready_d;
      awaddr_q  <= awaddr_d;
      awsize_q  <= awsize_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      empty_q   <= empty_d;
    end
  end

  assign awid    = AXI_ID;
  assign awlen   = 8'd0;
  assign awburst = BURST_INCR;
  assign awaddr  = awaddr_q;
  assign awsize  = awsize_q;
  assign awvalid = awvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = wlast_q;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;
  assign empty   = empty_q;

endmodule

// File: tb/tb_uncache_wbuf.sv
// Directed self-checking bench for uncache_wbuf.
module tb_uncache_wbuf;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_en;
  logic [3:0]  req_wen;
  logic [31:0] req_addr, req_wdata;
  logic        stall, empty;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic        bvalid, bready;
  logic [1:0]  bresp;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] wq[$];

  uncache_wbuf #(.DEPTH(4), .AXI_ID(4'd1)) dut (
    .clk(clk), .rst(rst), .req_en(req_en), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall), .empty(empty), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready)
  );

  always #5 clk = ~clk;

  // Record accepted W beats in order
  always @(posedge clk) begin
    if (!rst && wvalid && wready) wq.push_back(wdata);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    req_en    = 1'b1;
    req_addr  = a;
    req_wen   = w;
    req_wdata = d;
  endtask

  // One store with all ready signals high; checks each phase of the handshake
  task automatic run_one(input string nm, input logic [31:0] a, input logic [3:0] w,
                         input logic [31:0] d, input logic [31:0] exp_addr,
                         input logic [2:0] exp_size);
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    drive_req(a, w, d);
    #1 check({nm, "_stall"}, stall, 0);
    tick();
    req_en = 1'b0;
    check({nm, "_empty_after_push"}, empty, 0);
    check({nm, "_awvalid_early"}, awvalid, 0);
    tick();
    check({nm, "_awvalid"}, awvalid, 1);
    check({nm, "_awaddr"}, awaddr, exp_addr);
    check({nm, "_awsize"}, awsize, exp_size);
    check({nm, "_awlen"}, awlen, 0);
    check({nm, "_awburst"}, awburst, 1);
    check({nm, "_awid"}, awid, 1);
    tick();
    check({nm, "_aw_drop"}, awvalid, 0);
    check({nm, "_wvalid"}, wvalid, 1);
    check({nm, "_wlast"}, wlast, 1);
    check({nm, "_wstrb"}, wstrb, w);
    check({nm, "_wdata"}, wdata, d);
    tick();
    check({nm, "_w_drop"}, wvalid, 0);
    check({nm, "_bready"}, bready, 1);
    tick();
    check({nm, "_b_drop"}, bready, 0);
    check({nm, "_empty_done"}, empty, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fd [5];
    int          sz_before;
    int          n_aw;
    fd[0] = 32'h1111_1111; fd[1] = 32'h2222_2222; fd[2] = 32'h3333_3333;
    fd[3] = 32'h4444_4444; fd[4] = 32'h5555_5555;

    rst = 1'b1; req_en = 1'b0; req_wen = '0; req_addr = '0; req_wdata = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;

    // Reset state
    #2;
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_wlast", wlast, 0);
    check("rst_awaddr", awaddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_wstrb", wstrb, 0);
    check("rst_awsize", awsize, 0);
    check("rst_empty", empty, 1);
    req_en = 1'b1;
    #1 check("rst_stall", stall, 0);
    req_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Single word, byte and halfword stores
    run_one("word", 32'hBFAF_F000, 4'b1111, 32'h1234_5678, 32'hBFAF_F000, 3'd2);
    run_one("byte", 32'h1FD0_0003, 4'b1000, 32'hAB00_0000, 32'h1FD0_0003, 3'd0);
    run_one("half", 32'h0000_0100, 4'b1100, 32'hBEEF_0000, 32'h0000_0102, 3'd1);
    run_one("b1",   32'h0000_0204, 4'b0010, 32'h0000_5A00, 32'h0000_0205, 3'd0);

    // Full: AW blocked, five back-to-back pushes
    wq.delete();
    awready = 1'b0; wready = 1'b1; bvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_req(32'h0000_1000 + 32'(i * 4), 4'b1111, fd[i]);
      #1 check($sformatf("full_stall%0d", i), stall, 0);
      tick();
    end
    drive_req(32'h0000_1010, 4'b1111, fd[4]);
    #1 check("full_stall4", stall, 1);
    check("full_awaddr_head", awaddr, 32'h0000_1000);
    awready = 1'b1;
    tick();
    check("full_stall_in_w", stall, 1);
    tick();
    check("full_stall_in_b", stall, 1);
    tick();
    check("full_stall_after_pop", stall, 0);
    tick();
    req_en = 1'b0;
    for (int k = 0; k < 80 && !empty; k++) tick();
    check("full_drain_empty", empty, 1);
    check("full_beats", wq.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < wq.size()) check($sformatf("full_order%0d", i), wq[i], fd[i]);
    end

    // Backpressure on W and B
    awready = 1'b1; wready = 1'b0; bvalid = 1'b0;
    drive_req(32'h0000_2000, 4'b0011, 32'hCAFE_BABE);
    tick();
    req_en = 1'b0;
    tick();
    tick();
    check("bp_awaddr", awaddr, 32'h0000_2000);
    check("bp_awsize", awsize, 1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("bp_wvalid%0d", i), wvalid, 1);
      check($sformatf("bp_wdata%0d", i), wdata, 32'hCAFE_BABE);
      check($sformatf("bp_wstrb%0d", i), wstrb, 4'b0011);
      check($sformatf("bp_empty%0d", i), empty, 0);
      tick();
    end
    wready = 1'b1;
    tick();
    wready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("bp_bready%0d", i), bready, 1);
      check($sformatf("bp_nopop%0d", i), empty, 0);
      tick();
    end
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    check("bp_bready_drop", bready, 0);
    check("bp_empty_done", empty, 1);

    // Reset while in W with a second entry queued
    awready = 1'b1; wready = 1'b0; bvalid = 1'b1;
    drive_req(32'h0000_3000, 4'b1111, 32'hDEAD_0001);
    tick();
    drive_req(32'h0000_3004, 4'b1111, 32'hDEAD_0002);
    tick();
    req_en = 1'b0;
    tick();
    check("rstw_in_w", wvalid, 1);
    sz_before = wq.size();
    #2 rst = 1'b1;
    #1;
    check("rstw_awvalid", awvalid, 0);
    check("rstw_wvalid", wvalid, 0);
    check("rstw_bready", bready, 0);
    check("rstw_wlast", wlast, 0);
    check("rstw_empty", empty, 1);
    @(negedge clk);
    rst = 1'b0;
    wready = 1'b1;
    n_aw = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (awvalid) n_aw++;
    end
    check("rstw_no_aw", n_aw, 0);
    check("rstw_no_w", wq.size(), sz_before);
    check("rstw_empty_after", empty, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uncache_wbuf.md
# uncache_wbuf

Uncached store write buffer: the write-side counterpart of the uncached load data path. Accepts uncached stores from the data-SRAM-side request port, queues them in a small FIFO, and drains them in order as single-beat AXI write transactions (AW, then W, then B). Sits between the memory stage's uncached request decode and the AXI bridge. `empty` tells the load path when an uncached load may issue safely.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, 2–16.
- `AXI_ID`, 4'd1: constant driven on `awid`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_en` in 1: uncached store request this cycle.
- `req_wen` in 4: byte enables. Legal values: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
- `req_addr` in 32: store address.
- `req_wdata` in 32: store data, already lane-aligned.
- `stall` out 1: request not accepted; the requester holds it.
- `empty` out 1: FIFO empty and no transaction outstanding.
- `awid` out 4, `awaddr` out 32, `awlen` out 8, `awsize` out 3, `awburst` out 2, `awvalid` out 1, `awready` in 1.
- `wdata` out 32, `wstrb` out 4, `wlast` out 1, `wvalid` out 1, `wready` in 1.
- `bvalid` in 1, `bresp` in 2, `bready` out 1.

## Operation
- **Push:** occurs when `req_en & ~full`. `full` = (count == DEPTH).
  - Each entry stores {addr, wen, wdata}.
  - `stall = req_en & full` (combinational).
- **Drain FSM states:** IDLE, AW, W, B.
  - IDLE→AW when count != 0. On entry, the head entry is latched into the output registers.
  - AW: `awvalid`=1; AW→W on `awready`.
  - W: `wvalid`=1, `wlast`=1; W→B on `wready`.
  - B: `bready`=1. On `bvalid`: pop the head, go B→IDLE. `bresp` is ignored; no retry.
- **AW field derivation from the entry:**
  - `awaddr[31:2]` = addr[31:2].
  - `awaddr[1:0]` = index of the lowest set bit of wen.
  - `awsize`: 2 for wen=1111, 1 for 0011/1100, 0 for single-byte enables.
  - `awlen`=0, `awburst`=2'b01, `wstrb`=wen, `wdata`=entry data.
- **Ordering:** strictly FIFO, with at most one AXI write outstanding.
- **Empty:** `empty` = (count==0) & (state==IDLE).
- **Same-cycle push and pop when full:** the push is rejected (`stall`=1). `full` uses the current count, so the pop does not free space in that cycle.
- **Same-cycle push and pop when not full:** both happen; count is unchanged.
- **Pointers:** log2(DEPTH) bits, natural wrap. Count is log2(DEPTH)+1 bits.
- **Reset mid-transaction:** abandons everything. Any in-flight AXI write is dropped (system reset also resets the interconnect).

## Timing
- **Reset values:**
  - state=IDLE, count=0, pointers=0.
  - `awvalid`=`wvalid`=`bready`=`wlast`=0.
  - `awaddr`=`wdata`=0, `wstrb`=0, `awsize`=0.
  - `empty`=1; `stall` follows `req_en` & 0 = 0.
- **Latency:** a push at cycle N gives IDLE→AW at N+1, with `awvalid` high in cycle N+1 at the earliest.
- **Best case (ready signals tied high):**
  - N+1 AW, N+2 W, N+3 B with `bvalid`, pop at the N+3 edge.
  - IDLE in N+4; next entry AW at N+5.
  - Throughput: 1 store per 4 cycles.
- **AXI hold rules:** `awvalid`/`wvalid` stay asserted, with stable payload, until accepted. They never depend combinationally on `*ready`.
- **Registered outputs:** all AXI outputs are registered. `stall` is the only combinational output.

## Structure
- **Shared defines header:**
  - FSM state encodings.
  - AXI size constants (SIZE_B/H/W).
  - BURST_INCR.
- **Sub-module `wbuf_fifo`:** parameterised sync FIFO (push, pop, din, dout, count, full, empty) with async active-high reset.
- **Top level:** the FSM and the wen→size/offset decode.

## Test plan
- **Single word:** push addr 0xBFAF_F000, wen 1111, data 0x1234_5678, all ready=1 → `awvalid` at +1 (awaddr 0xBFAF_F000, awsize 2), `wvalid` at +2 (wstrb 1111), `bready` at +3, `empty`=1 at +4.
- **Byte store:** push addr 0x1FD0_0003, wen 1000 → awaddr 0x1FD0_0003, awsize 0, wstrb 1000.
- **Full:** with `awready`=0, push 5 stores back to back → stalls 0,0,0,0,1. Then raise `awready` → the 5th push is accepted only after the first pop, and order is preserved on `wdata`.
- **Backpressure:** `wready` held low 6 cycles → `wvalid` and `wdata` stable throughout; no pop until `bvalid`.
- **Reset mid-W:** assert `rst` asynchronously with 2 entries queued → all valids drop immediately, `empty`=1, and no write issues after release.
